// File: rtl/usb_rx_line_decoder.sv
// USB full-speed receive bit stage: line synchroniser, bit timing recovery, NRZI decode,
// SYNC check, bit unstuffing and LSB-first byte assembly with EOP / line-error strobes.
module usb_rx_line_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dplus_in,
  input  logic       dminus_in,
  output logic       packet_active,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       eop,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic [2:0] state_dbg
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SYNC     = 3'd1,
    S_DATA     = 3'd2,
    S_EOP_WAIT = 3'd3,
    S_ERR      = 3'd4
  } state_t;

  // Handshake: none. byte_valid, eop and rx_err are one-cycle strobes the consumer must
  // take when high; byte_data and err_code hold their values between strobes.

  logic          dp_s1_q, dp_s2_q, dm_s1_q, dm_s2_q, dp_prev_q, dm_prev_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          prev_level_q, prev_level_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [2:0]    ones_q, ones_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic          byte_valid_q, byte_valid_d;
  logic          eop_q, eop_d;
  logic          rx_err_q, rx_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          packet_active_q, packet_active_d;

  logic line_j, line_k, line_se0, resync, sample, bit_val;

  always_comb begin
    line_j   = dp_s2_q & ~dm_s2_q;
    line_k   = ~dp_s2_q & dm_s2_q;
    line_se0 = ~(line_j | line_k);
    resync   = (dp_s2_q != dp_prev_q);
    sample   = (timer_q == TW'(SAMPLE_POINT));
    // Level encoded as 1 = J, 0 = K; a repeated level decodes as a 1.
    bit_val  = (line_j == prev_level_q);
  end

  always_comb begin
    state_d         = state_q;
    prev_level_d    = prev_level_q;
    cnt_d           = cnt_q;
    bitcnt_d        = bitcnt_q;
    ones_d          = ones_q;
    shift_d         = shift_q;
    byte_data_d     = byte_data_q;
    byte_valid_d    = 1'b0;
    eop_d           = 1'b0;
    rx_err_d        = 1'b0;
    err_code_d      = err_code_q;
    packet_active_d = packet_active_q;
    if (resync || timer_q == TW'(CLKS_PER_BIT - 1)) timer_d = '0;
    else                                             timer_d = timer_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        timer_d      = '0;
        prev_level_d = 1'b1;
        cnt_d        = 3'd0;
        if (line_k && dp_prev_q && !dm_prev_q) begin
          state_d         = S_SYNC;
          packet_active_d = 1'b1;
        end
      end
      S_SYNC: if (sample) begin
        if (line_se0 || (bit_val != (cnt_q == 3'd7))) begin
          state_d    = S_ERR;
          rx_err_d   = 1'b1;
          err_code_d = 2'b01;
          cnt_d      = 3'd0;
        end else begin
          prev_level_d = line_j;
          cnt_d        = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d  = S_DATA;
            ones_d   = 3'd0;
            bitcnt_d = 3'd0;
          end
        end
      end
      S_DATA: if (sample) begin
        if (line_se0) begin
          state_d = S_EOP_WAIT;
          if (bitcnt_q != 3'd0) begin
            rx_err_d   = 1'b1;
            err_code_d = 2'b11;
          end
        end else begin
          prev_level_d = line_j;
          if (ones_q == 3'd6) begin
            // Stuffed bit: must be 0 and is discarded.
            if (bit_val) begin
              state_d    = S_ERR;
              rx_err_d   = 1'b1;
              err_code_d = 2'b10;
              cnt_d      = 3'd0;
            end else begin
              ones_d = 3'd0;
            end
          end else begin
            shift_d  = {bit_val, shift_q[7:1]};
            ones_d   = bit_val ? ones_q + 3'd1 : 3'd0;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              byte_data_d  = {bit_val, shift_q[7:1]};
              byte_valid_d = 1'b1;
            end
          end
        end
      end
      S_EOP_WAIT: if (sample) begin
        if (line_j) begin
          state_d         = S_IDLE;
          eop_d           = 1'b1;
          packet_active_d = 1'b0;
        end else if (line_k) begin
          state_d    = S_ERR;
          rx_err_d   = 1'b1;
          err_code_d = 2'b10;
          cnt_d      = 3'd0;
        end
      end
      S_ERR: if (sample) begin
        if (line_j) begin
          if (cnt_q == 3'd7) begin
            state_d         = S_IDLE;
            packet_active_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          cnt_d = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_s1_q         <= 1'b0;
      dp_s2_q         <= 1'b0;
      dm_s1_q         <= 1'b0;
      dm_s2_q         <= 1'b0;
      dp_prev_q       <= 1'b0;
      dm_prev_q       <= 1'b0;
      state_q         <= S_IDLE;
      timer_q         <= '0;
      prev_level_q    <= 1'b1;
      cnt_q           <= 3'd0;
      bitcnt_q        <= 3'd0;
      ones_q          <= 3'd0;
      shift_q         <= 8'h00;
      byte_data_q     <= 8'h00;
      byte_valid_q    <= 1'b0;
      eop_q           <= 1'b0;
      rx_err_q        <= 1'b0;
      err_code_q      <= 2'b00;
      packet_active_q <= 1'b0;
    end else begin
      dp_s1_q         <= dplus_in;
      dp_s2_q         <= dp_s1_q;
      dm_s1_q         <= dminus_in;
      dm_s2_q         <= dm_s1_q;
      dp_prev_q       <= dp_s2_q;
      dm_prev_q       <= dm_s2_q;
      state_q         <= state_d;
      timer_q         <= timer_d;
      prev_level_q    <= prev_level_d;
      cnt_q           <= cnt_d;
      bitcnt_q        <= bitcnt_d;
      ones_q          <= ones_d;
      shift_q         <= shift_d;
      byte_data_q     <= byte_data_d;
      byte_valid_q    <= byte_valid_d;
      eop_q           <= eop_d;
      rx_err_q        <= rx_err_d;
      err_code_q      <= err_code_d;
      packet_active_q <= packet_active_d;
    end
  end

  assign packet_active = packet_active_q;
  assign byte_data     = byte_data_q;
  assign byte_valid    = byte_valid_q;
  assign eop           = eop_q;
  assign rx_err        = rx_err_q;
  assign err_code      = err_code_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Bench for usb_rx_line_decoder: builds USB line waveforms from byte lists (NRZI + stuffing)
// and checks emitted bytes, EOP and error strobes against the packet-level expectation.
module tb_usb_rx_line_decoder;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dp = 1'b1;
  logic       dm = 1'b0;
  logic       packet_active, byte_valid, eop, rx_err;
  logic [7:0] byte_data;
  logic [1:0] err_code;
  logic [2:0] state_dbg;

  usb_rx_line_decoder #(.CLKS_PER_BIT(8), .SAMPLE_POINT(3)) dut (
    .clk(clk), .rst(rst), .dplus_in(dp), .dminus_in(dm),
    .packet_active(packet_active), .byte_data(byte_data), .byte_valid(byte_valid),
    .eop(eop), .rx_err(rx_err), .err_code(err_code), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  int         n_eop = 0;
  int         n_err = 0;
  logic [1:0] last_code = 2'b00;
  bit         alt_mode = 1'b0;
  bit         alt_phase = 1'b0;
  bit         cur_j = 1'b1;
  int         ones_tx = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every byte strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (byte_valid) begin
        chk("byte_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("byte_data", byte_data, e);
        end
      end
      if (byte_valid || eop) chk("bv_eop_excl", byte_valid & eop, 0);
      if (eop) n_eop++;
      if (rx_err) begin
        n_err++;
        last_code = err_code;
      end
    end
  end

  task automatic drive(input logic [1:0] st, input int clocks);
    {dp, dm} = st;
    repeat (clocks) @(negedge clk);
  endtask

  task automatic send_nrzi(input bit b);
    int len;
    if (!b) cur_j = ~cur_j;
    if (alt_mode) begin
      alt_phase = ~alt_phase;
      len = alt_phase ? 7 : 9;
    end else begin
      len = 8;
    end
    drive(cur_j ? LJ : LK, len);
  endtask

  task automatic send_data_bit(input bit b);
    send_nrzi(b);
    ones_tx = b ? ones_tx + 1 : 0;
    if (ones_tx == 6) begin
      send_nrzi(1'b0);
      ones_tx = 0;
    end
  endtask

  task automatic send_sync();
    cur_j = 1'b1;
    for (int i = 0; i < 8; i++) send_nrzi(i == 7);
    ones_tx = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_data_bit(b[i]);
  endtask

  task automatic send_eop();
    drive(LSE0, 16);
    cur_j = 1'b1;
    drive(LJ, 8);
  endtask

  task automatic end_pkt(input string tag, input int exp_eop, input int exp_err,
                         input logic [1:0] exp_code);
    drive(LJ, 12 * 8);
    chk({tag, "_bytes_left"}, exp_q.size(), 0);
    chk({tag, "_eop"}, n_eop, exp_eop);
    chk({tag, "_rx_err"}, n_err, exp_err);
    if (exp_err != 0) chk({tag, "_err_code"}, last_code, exp_code);
    chk({tag, "_pkt_active"}, packet_active, 0);
    exp_q.delete();
    n_eop = 0;
    n_err = 0;
  endtask

  task automatic good_pkt(input string tag, input int nb);
    logic [7:0] b[$];
    for (int i = 0; i < nb; i++) begin
      b.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      exp_q.push_back(b[i]);
    end
    send_sync();
    foreach (b[i]) send_byte(b[i]);
    send_eop();
    end_pkt(tag, 1, 0, 2'b00);
  endtask

  initial begin
    logic [7:0] sb;
    int         n, k;
    // 1: reset and idle J
    {dp, dm} = LJ;
    repeat (2) @(negedge clk);
    chk("rst_pkt_active", packet_active, 0);
    chk("rst_state", state_dbg, 0);
    rst = 1'b0;
    drive(LJ, 50);
    chk("idle_pkt_active", packet_active, 0);
    chk("idle_byte_valid", byte_valid, 0);
    chk("idle_byte_data", byte_data, 0);
    chk("idle_eop", eop, 0);
    chk("idle_rx_err", rx_err, 0);
    chk("idle_err_code", err_code, 0);
    chk("idle_events", n_eop + n_err, 0);

    // 2: single byte A5
    exp_q.push_back(8'hA5);
    send_sync();
    send_byte(8'hA5);
    send_eop();
    end_pkt("a5", 1, 0, 2'b00);

    // 3: FF, 7E with stuffed zeros
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h7E);
    send_sync();
    send_byte(8'hFF);
    send_byte(8'h7E);
    send_eop();
    end_pkt("ff7e", 1, 0, 2'b00);

    for (int r = 0; r < 6; r++) good_pkt("rand_good", $urandom_range(0, 4));

    // 4: seven ones straight after SYNC, then recovery timing
    send_sync();
    for (int i = 0; i < 7; i++) send_nrzi(1'b1);
    cur_j = 1'b1;
    drive(LJ, 7 * 8);
    chk("stuff_err_still_active", packet_active, 1);
    chk("stuff_err_code_early", err_code, 2'b10);
    drive(LJ, 2 * 8);
    chk("stuff_err_recovered", packet_active, 0);
    end_pkt("stuff7", 0, 1, 2'b10);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(0, 2);
      send_sync();
      for (int i = 0; i < n; i++) begin
        sb = 8'($urandom);
        exp_q.push_back(sb);
        send_byte(sb);
      end
      for (int i = 0; i < 7; i++) send_nrzi(1'b1);
      cur_j = 1'b1;
      end_pkt("rand_stuff", 0, 1, 2'b10);
    end

    // 5: bad SYNC KJKJKJKJ and random single-bit SYNC corruption
    cur_j = 1'b1;
    for (int i = 0; i < 8; i++) send_nrzi(1'b0);
    cur_j = 1'b1;
    end_pkt("bad_sync", 0, 1, 2'b01);
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, 7);
      cur_j = 1'b1;
      for (int i = 0; i < 8; i++) send_nrzi((i == 7) ^ (i == k));
      cur_j = 1'b1;
      end_pkt("rand_bad_sync", 0, 1, 2'b01);
    end

    // SE0 on a partial byte
    send_sync();
    for (int i = 0; i < 4; i++) send_data_bit(1'(i & 1));
    send_eop();
    end_pkt("partial4", 1, 1, 2'b11);
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(0, 2);
      k = $urandom_range(1, 7);
      send_sync();
      for (int i = 0; i < n; i++) begin
        sb = 8'($urandom);
        exp_q.push_back(sb);
        send_byte(sb);
      end
      for (int i = 0; i < k; i++) send_data_bit(1'($urandom_range(0, 1)));
      send_eop();
      end_pkt("rand_partial", 1, 1, 2'b11);
    end

    // 6: reset mid-byte
    send_sync();
    for (int i = 0; i < 4; i++) send_data_bit(1'($urandom_range(0, 1)));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", state_dbg, 0);
    chk("midrst_pkt_active", packet_active, 0);
    chk("midrst_outputs", {byte_valid, eop, rx_err, err_code, byte_data}, 0);
    rst = 1'b0;
    cur_j = 1'b1;
    end_pkt("midrst", 0, 0, 2'b00);

    // Bit period alternating 7/9 clocks
    alt_mode = 1'b1;
    for (int r = 0; r < 4; r++) good_pkt("alt79", $urandom_range(1, 3));
    alt_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
